uart_tx_fifo_param: RTL and testbench
=====================================

Name: uart_tx_fifo_param

Overview:
Parametrised next-generation UART transmitter. It adds a configurable data width, runtime-selectable parity and stop-bit count, an input FIFO with a valid/ready handshake, and back-to-back framing with no idle gap. It sits between the CPU/peripheral bus write path and the serial TX pin. Bit timing comes from an external one-clk-wide baud_tick enable, and all logic is synchronous to clk.

Parameters:
DATA_W, 8, data bits per frame; legal range 5..9.
FIFO_DEPTH, 4, input FIFO entries; power of two, at least 2.
CNT_W, $clog2(FIFO_DEPTH)+1, width of fifo_count.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
baud_tick  in  1  one-clk pulse per bit period
in_data  in  DATA_W  word to transmit
in_valid  in  1  in_data is valid
in_ready  out  1  FIFO can accept a word (equals !fifo_full)
parity_en  in  1  append a parity bit
parity_odd  in  1  1 = odd parity, 0 = even parity
two_stop  in  1  1 = two stop bits, 0 = one stop bit
tx  out  1  serial line; idle high
tx_busy  out  1  a frame is in progress
tx_done  out  1  one-clk pulse at the end of each frame
fifo_count  out  CNT_W  number of words held in the FIFO
fifo_full  out  1  fifo_count == FIFO_DEPTH
fifo_empty  out  1  fifo_count == 0

Behaviour:
- Reset is asynchronous and active-low. While reset_n=0: tx=1, tx_busy=0, tx_done=0, fifo_count=0, fifo_empty=1, fifo_full=0, in_ready=1, state=IDLE. FIFO pointers are cleared.
- Reset mid-frame aborts the frame immediately. tx returns to 1 without completing the frame, and queued data is discarded.
- Push: when in_valid && in_ready is high at a clk edge, the word is written to the FIFO.
- Full FIFO: in_ready=0 and the word is not accepted; the sender must hold it.
- Pop and push in the same cycle leave fifo_count unchanged.
- No fall-through: a word pushed in cycle N can be popped at the earliest in cycle N+1.
- Line timing: tx changes only on a clk edge where baud_tick=1. Each bit lasts exactly one baud period.
- States:
  - IDLE: tx=1, tx_busy=0. On baud_tick with !fifo_empty: pop the head into the shift register, latch parity_en, parity_odd and two_stop, drive tx<=0, set tx_busy<=1, go to START.
  - START: on baud_tick, drive tx<=d[0], set bit index=0, go to DATA.
  - DATA: on baud_tick, if the index is DATA_W-1, go to PARITY (if parity_en) or STOP1; otherwise drive tx<=d[index+1] and increment the index. Bits go out LSB first.
  - PARITY: the bit is XOR of all data bits, inverted when parity_odd=1. On baud_tick, go to STOP1.
  - Entering STOP1 drives tx<=1.
  - STOP1: on baud_tick, go to STOP2 if two_stop, otherwise end the frame.
  - STOP2: on baud_tick, end the frame.
- Frame end (on the ending baud_tick):
  - tx_done pulses for that one cycle.
  - If the FIFO is non-empty: pop the next word, drive tx<=0, go to START. tx_busy stays 1 and there is no idle bit between frames.
  - Otherwise: go to IDLE, and tx_busy<=0 in the same cycle.
- Frame length is 1 + DATA_W + parity_en + (two_stop ? 2 : 1) baud periods.
- Config inputs that change mid-frame do not affect the current frame.
- baud_tick while reset_n=0 is ignored.
- Illegal or unused state encodings go to IDLE with tx=1.

Decomposition:
- Package uart_pkg holds:
  - state enum: IDLE, START, DATA, PARITY, STOP1, STOP2;
  - localparams for the legal DATA_W range;
  - a parity helper function.
- Sub-module uart_sync_fifo (parameters WIDTH, DEPTH) provides push/pop, count, full and empty, with the same asynchronous active-low reset.
- The top level holds the framing FSM, shift register and bit counter.

Test Plan:
- Defaults, baud_tick every 4 clks, push 0xA5 with parity off and one stop bit. Sampled per baud period, tx reads 0,1,0,1,0,0,1,0,1,1. tx_done pulses once, then tx_busy falls.
- parity_en=1: push 0xA5 with parity_odd=0, then again with parity_odd=1. The parity bit is 0 for even and 1 for odd, with an 11-period frame each time.
- two_stop=1, push 0x3C, then push 0xFF while the first frame is running. Frames are exactly 11 periods each with no idle gap between them. tx_busy stays 1 throughout and tx_done pulses twice.
- Push 5 words into an empty FIFO (depth 4) with baud_tick held 0. After 4 words, fifo_full=1, in_ready=0 and fifo_count=4. The 5th word is not accepted until the first pop.
- Pull reset_n low mid-DATA of 0x55. tx is 1 immediately and fifo_count=0. After reset_n is released, with no new push, the line stays idle high.
- DATA_W=7 build, push 0x41 with parity on and even. The frame is 0,1,0,0,0,0,0,1,0,1: 10 periods, with parity bit 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART transmitter.
package uart_pkg;

    // Framing FSM states; encodings 6 and 7 are unused and recover to IDLE.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP1  = 3'd4,
        STOP2  = 3'd5
    } state_e;

    // Legal data-bits-per-frame range.
    localparam int DATA_W_MIN = 5;
    localparam int DATA_W_MAX = 9;

    // Parity over a zero-extended data word; odd=1 inverts the even result.
    function automatic logic parity_bit(input logic [DATA_W_MAX-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with registered count; read data is the current head
// (no fall-through: a word written this cycle is visible as head next cycle).
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // Pointer and count update; pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state; storage contents need no reset because pointers are cleared.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/uart_tx_fifo_param.sv
// UART transmitter: input FIFO, framing FSM with optional parity and
// one/two stop bits, back-to-back frames with no idle gap.
module uart_tx_fifo_param
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              baud_tick,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              parity_en,
    input  logic              parity_odd,
    input  logic              two_stop,
    output logic              tx,
    output logic              tx_busy,
    output logic              tx_done,
    output logic [CNT_W-1:0]  fifo_count,
    output logic              fifo_full,
    output logic              fifo_empty
);
    localparam int IDX_W = $clog2(DATA_W);

    if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX) begin : g_bad_data_w
        $error("uart_tx_fifo_param: DATA_W out of range");
    end

    state_e            state_q, state_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              tx_q, tx_d, busy_q, busy_d, done_q, done_d;
    logic              par_en_q, par_en_d, par_q, par_d, two_stop_q, two_stop_d;
    logic              load, frame_end;
    logic [DATA_W-1:0] fifo_rdata;

    assign in_ready = !fifo_full;
    assign tx       = tx_q;
    assign tx_busy  = busy_q;
    assign tx_done  = done_q;

    uart_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (in_valid && in_ready),
        .wdata   (in_data),
        .pop     (load),
        .rdata   (fifo_rdata),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Framing FSM: every line change happens on a baud tick; a frame end with
    // data waiting reloads straight into START so no idle bit is inserted.
    always_comb begin
        state_d    = state_q;
        sh_d       = sh_q;
        idx_d      = idx_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        par_en_d   = par_en_q;
        par_d      = par_q;
        two_stop_d = two_stop_q;
        load       = 1'b0;
        frame_end  = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (baud_tick && !fifo_empty) load = 1'b1;
            end
            START: if (baud_tick) begin
                tx_d    = sh_q[0];
                sh_d    = sh_q >> 1;
                idx_d   = '0;
                state_d = DATA;
            end
            DATA: if (baud_tick) begin
                if (idx_q == IDX_W'(DATA_W - 1)) begin
                    if (par_en_q) begin
                        tx_d    = par_q;
                        state_d = PARITY;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = STOP1;
                    end
                end else begin
                    tx_d  = sh_q[0];
                    sh_d  = sh_q >> 1;
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            PARITY: if (baud_tick) begin
                tx_d    = 1'b1;
                state_d = STOP1;
            end
            STOP1: if (baud_tick) begin
                if (two_stop_q) state_d = STOP2;
                else            frame_end = 1'b1;
            end
            STOP2: if (baud_tick) frame_end = 1'b1;
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
        if (frame_end) begin
            done_d = 1'b1;
            if (!fifo_empty) begin
                load = 1'b1;
            end else begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        end
        // Config is captured with the word so mid-frame changes cannot leak in.
        if (load) begin
            sh_d       = fifo_rdata;
            par_en_d   = parity_en;
            par_d      = parity_bit(DATA_W_MAX'(fifo_rdata), parity_odd);
            two_stop_d = two_stop;
            tx_d       = 1'b0;
            busy_d     = 1'b1;
            state_d    = START;
        end
    end

    // Frame state registers; reset aborts any frame and parks the line high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            sh_q       <= '0;
            idx_q      <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            par_en_q   <= 1'b0;
            par_q      <= 1'b0;
            two_stop_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sh_q       <= sh_d;
            idx_q      <= idx_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            par_en_q   <= par_en_d;
            par_q      <= par_d;
            two_stop_q <= two_stop_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Bench for uart_tx_fifo_param: table of single frames, hand sequences for
// back-to-back, FIFO full, DATA_W=7 and reset-abort, plus randomized traffic
// checked against a frame-level model of the serial line.
module tb_uart_tx_fifo_param;
  localparam int DW = 8;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef logic bitq_t[$];
  typedef struct { logic [7:0] d; logic pe; logic po; logic ts; string bits; } vec_t;

  logic clk = 1'b0, reset_n = 1'b0, baud_tick = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic in_valid = 1'b0, parity_en = 1'b0, parity_odd = 1'b0, two_stop = 1'b0;
  logic in_ready, tx, tx_busy, tx_done, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;

  logic [6:0] in_data7 = '0;
  logic in_valid7 = 1'b0, parity_en7 = 1'b0, parity_odd7 = 1'b0, two_stop7 = 1'b0;
  logic in_ready7, tx7, tx_busy7, tx_done7, fifo_full7, fifo_empty7;
  logic [CW-1:0] fifo_count7;

  uart_tx_fifo_param #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .baud_tick(baud_tick), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .parity_en(parity_en),
    .parity_odd(parity_odd), .two_stop(two_stop), .tx(tx), .tx_busy(tx_busy),
    .tx_done(tx_done), .fifo_count(fifo_count), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty));

  uart_tx_fifo_param #(.DATA_W(7), .FIFO_DEPTH(DEPTH)) dut7 (
    .clk(clk), .reset_n(reset_n), .baud_tick(baud_tick), .in_data(in_data7),
    .in_valid(in_valid7), .in_ready(in_ready7), .parity_en(parity_en7),
    .parity_odd(parity_odd7), .two_stop(two_stop7), .tx(tx7), .tx_busy(tx_busy7),
    .tx_done(tx_done7), .fifo_count(fifo_count7), .fifo_full(fifo_full7),
    .fifo_empty(fifo_empty7));

  always #5 clk = ~clk;

  // baud tick: one clk in every four while enabled, driven off the falling edge
  bit tick_en = 1'b0;
  int tcnt = 0;
  always @(negedge clk) begin
    if (!tick_en) begin tcnt = 0; baud_tick = 1'b0; end
    else begin tcnt = (tcnt + 1) % 4; baud_tick = (tcnt == 0); end
  end

  // line monitor: one sample per baud period while a frame is on the line
  logic cap_q[$];
  logic cap7_q[$];
  int done_tick_q[$];
  int done_cnt = 0, done7_cnt = 0, tick_cnt = 0, glitch = 0, busy_fall = 0;
  logic prev_tx = 1'b1, prev_busy = 1'b0;
  bit prev_ok = 1'b0;
  always @(posedge clk) begin
    #1;
    if (reset_n) begin
      if (baud_tick) begin
        tick_cnt++;
        if (tx_busy) cap_q.push_back(tx);
        if (tx_busy7) cap7_q.push_back(tx7);
      end
      if (tx_done) begin done_cnt++; done_tick_q.push_back(tick_cnt); end
      if (tx_done7) done7_cnt++;
      if (prev_ok && !baud_tick && tx !== prev_tx) glitch++;
      if (prev_ok && prev_busy && !tx_busy) busy_fall++;
      prev_tx = tx; prev_busy = tx_busy; prev_ok = 1'b1;
    end else begin
      prev_ok = 1'b0;
    end
  end

  // reference model: the bit sequence a frame puts on the line
  logic exp_q[$];
  function automatic void add_frame(input logic [DW-1:0] d, input logic pe, input logic po,
                                    input logic ts);
    int ones = 0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < DW; i++) begin
      exp_q.push_back(d[i]);
      if (d[i]) ones++;
    end
    if (pe) exp_q.push_back(po ? (ones % 2 == 0) : (ones % 2 == 1));
    exp_q.push_back(1'b1);
    if (ts) exp_q.push_back(1'b1);
  endfunction

  function automatic bitq_t str2q(input string s);
    bitq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i] == "1");
    return q;
  endfunction

  int total = 0, bad = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic cmp_stream(input string nm, input bit use7, input int cb, input bitq_t want);
    bitq_t got;
    int first = -1;
    if (use7) got = cap7_q[cb:$];
    else      got = cap_q[cb:$];
    for (int i = 0; i < want.size(); i++)
      if (first < 0 && (i >= got.size() || got[i] !== want[i])) first = i;
    chk({nm, " frame_len"}, 32'(got.size()), 32'(want.size()));
    chk({nm, " first_bad_bit"}, 32'(first), 32'hffff_ffff);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    int n = 0;
    @(negedge clk);
    in_data = w; in_valid = 1'b1;
    while (!in_ready && n < 2000) begin @(negedge clk); n++; end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL push_timeout: in_ready stuck 0 for word %0h", w);
    end else begin
      add_frame(w, parity_en, parity_odd, two_stop);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_frames(input string nm, input int db, input int n);
    int k = 0;
    while (!((done_cnt - db) >= n && !tx_busy) && k < 5000) begin @(negedge clk); k++; end
    if (k >= 5000) begin
      total++; bad++;
      $display("FAIL %s timeout: done=%0d want %0d", nm, done_cnt - db, n);
    end
  endtask

  task automatic wait_busy(input string nm);
    int k = 0;
    while (!tx_busy && k < 200) begin @(negedge clk); k++; end
    if (!tx_busy) begin
      total++; bad++;
      $display("FAIL %s busy_timeout: tx_busy=0 want 1", nm);
    end
  endtask

  vec_t vecs[6];

  initial begin
    int cb, db, dtb, n, k;
    logic [7:0] fw[5];

    vecs[0] = '{d: 8'hA5, pe: 1'b0, po: 1'b0, ts: 1'b0, bits: "0101001011"};
    vecs[1] = '{d: 8'hA5, pe: 1'b1, po: 1'b0, ts: 1'b0, bits: "01010010101"};
    vecs[2] = '{d: 8'hA5, pe: 1'b1, po: 1'b1, ts: 1'b0, bits: "01010010111"};
    vecs[3] = '{d: 8'h3C, pe: 1'b0, po: 1'b0, ts: 1'b1, bits: "00011110011"};
    vecs[4] = '{d: 8'h00, pe: 1'b1, po: 1'b1, ts: 1'b1, bits: "000000000111"};
    vecs[5] = '{d: 8'h81, pe: 1'b1, po: 1'b0, ts: 1'b1, bits: "010000001011"};

    // reset state
    cyc(3);
    chk("rst tx", 32'(tx), 32'd1);
    chk("rst tx_busy", 32'(tx_busy), 32'd0);
    chk("rst tx_done", 32'(tx_done), 32'd0);
    chk("rst fifo_count", 32'(fifo_count), 32'd0);
    chk("rst fifo_empty", 32'(fifo_empty), 32'd1);
    chk("rst fifo_full", 32'(fifo_full), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    reset_n = 1'b1;
    cyc(2);
    tick_en = 1'b1;

    // single frames from the table
    for (int v = 0; v < 6; v++) begin
      @(negedge clk);
      parity_en = vecs[v].pe; parity_odd = vecs[v].po; two_stop = vecs[v].ts;
      cb = cap_q.size(); db = done_cnt;
      push_word(vecs[v].d);
      wait_frames($sformatf("vec%0d", v), db, 1);
      cmp_stream($sformatf("vec%0d", v), 1'b0, cb, str2q(vecs[v].bits));
      chk($sformatf("vec%0d done_pulses", v), 32'(done_cnt - db), 32'd1);
      chk($sformatf("vec%0d busy_after", v), 32'(tx_busy), 32'd0);
    end

    // back-to-back frames, two stop bits
    @(negedge clk);
    parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b1;
    cb = cap_q.size(); db = done_cnt; dtb = done_tick_q.size(); k = busy_fall;
    push_word(8'h3C);
    wait_busy("b2b");
    push_word(8'hFF);
    wait_frames("b2b", db, 2);
    cmp_stream("b2b", 1'b0, cb, str2q({"00011110011", "01111111111"}));
    chk("b2b done_pulses", 32'(done_cnt - db), 32'd2);
    chk("b2b busy_falls", 32'(busy_fall - k), 32'd1);
    if (done_tick_q.size() >= dtb + 2)
      chk("b2b frame_spacing", 32'(done_tick_q[dtb+1] - done_tick_q[dtb]), 32'd11);
    else chk("b2b done_ticks", 32'(done_tick_q.size() - dtb), 32'd2);

    // FIFO fill with the line stalled
    @(negedge clk);
    tick_en = 1'b0; two_stop = 1'b0;
    fw[0] = 8'h11; fw[1] = 8'h22; fw[2] = 8'h33; fw[3] = 8'h44; fw[4] = 8'h5A;
    cb = cap_q.size(); db = done_cnt; n = exp_q.size();
    for (int i = 0; i < 4; i++) push_word(fw[i]);
    chk("full fifo_full", 32'(fifo_full), 32'd1);
    chk("full in_ready", 32'(in_ready), 32'd0);
    chk("full fifo_count", 32'(fifo_count), 32'd4);
    chk("full fifo_empty", 32'(fifo_empty), 32'd0);
    chk("full tx_busy", 32'(tx_busy), 32'd0);
    @(negedge clk);
    in_data = fw[4]; in_valid = 1'b1;
    cyc(6);
    chk("full held count", 32'(fifo_count), 32'd4);
    tick_en = 1'b1;
    push_word(fw[4]);
    chk("full refill busy", 32'(tx_busy), 32'd1);
    chk("full refill count", 32'(fifo_count), 32'd4);
    wait_frames("full", db, 5);
    cmp_stream("full", 1'b0, cb, exp_q[n:$]);

    // DATA_W=7 build, even parity
    @(negedge clk);
    cb = cap7_q.size(); db = done7_cnt;
    in_data7 = 7'h41; parity_en7 = 1'b1; parity_odd7 = 1'b0; in_valid7 = 1'b1;
    @(negedge clk);
    in_valid7 = 1'b0;
    k = 0;
    while (!(done7_cnt > db && !tx_busy7) && k < 2000) begin @(negedge clk); k++; end
    cmp_stream("dw7", 1'b1, cb, str2q("0100000101"));
    chk("dw7 done_pulses", 32'(done7_cnt - db), 32'd1);

    // randomized traffic against the model
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      parity_en = 1'($urandom_range(0, 1));
      parity_odd = 1'($urandom_range(0, 1));
      two_stop = 1'($urandom_range(0, 1));
      cb = cap_q.size(); db = done_cnt; n = exp_q.size();
      k = 4 + $urandom_range(0, 4);
      for (int i = 0; i < k; i++) begin
        cyc($urandom_range(0, 30));
        push_word(8'($urandom));
      end
      wait_frames($sformatf("rand%0d", b), db, k);
      cmp_stream($sformatf("rand%0d", b), 1'b0, cb, exp_q[n:$]);
      chk($sformatf("rand%0d done_pulses", b), 32'(done_cnt - db), 32'(k));
    end

    // reset in the middle of a frame with a word still queued
    @(negedge clk);
    parity_en = 1'b0; two_stop = 1'b0;
    push_word(8'h55);
    push_word(8'h12);
    wait_busy("rstmid");
    cyc(14);
    chk("rstmid pre count", 32'(fifo_count), 32'd1);
    @(negedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("rstmid tx", 32'(tx), 32'd1);
    chk("rstmid fifo_count", 32'(fifo_count), 32'd0);
    chk("rstmid tx_busy", 32'(tx_busy), 32'd0);
    chk("rstmid fifo_empty", 32'(fifo_empty), 32'd1);
    cyc(3);
    reset_n = 1'b1;
    cb = cap_q.size(); db = done_cnt;
    cyc(60);
    chk("rstmid idle samples", 32'(cap_q.size() - cb), 32'd0);
    chk("rstmid idle done", 32'(done_cnt - db), 32'd0);
    chk("rstmid idle tx", 32'(tx), 32'd1);

    chk("tx off-tick changes", 32'(glitch), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
